// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external req/ack memory port between the fetch
// (instruction) port and the data port of a stall-style pipeline. The data
// port has fixed priority. Per-port done flags ensure each request is
// serviced exactly once while the pipeline is frozen by the other stall.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_read_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_pend_s;
  logic i_pend_s;
  logic advance_s;
  logic ack_s;
  logic granted_live_s;

  // Pending/stall/advance decode and qualified completion
  always_comb begin
    d_pend_s  = (d_read_en | d_write_en) & ~d_done_q;
    i_pend_s  = if_read_en & ~if_done_q;
    advance_s = ~i_pend_s & ~d_pend_s;
    // mem_ack only counts while a transaction is outstanding
    ack_s     = (state_q == BUSY) & mem_ack;
    // Granted requester still holding its request when the ack lands
    if (grant_q == GNT_D) begin
      granted_live_s = d_read_en | d_write_en;
    end else begin
      granted_live_s = if_read_en;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_pend_s || i_pend_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request is active for the whole BUSY period
  always_comb begin
    case (state_q)
      BUSY:    mem_req = 1'b1;
      IDLE:    mem_req = 1'b0;
      default: mem_req = 1'b0;
    endcase
  end

  // Transaction capture in IDLE; data port wins, read+write counts as write
  always_comb begin
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == IDLE) begin
      if (d_pend_s) begin
        grant_d     = GNT_D;
        mem_we_d    = d_write_en;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else if (i_pend_s) begin
        grant_d     = GNT_I;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = mem_wdata_q;
      end else begin
        grant_d     = grant_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
      end
    end else begin
      grant_d     = grant_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end
  end

  // Done flags and read-data capture; advance releases both flags
  always_comb begin
    if_done_d  = if_done_q;
    d_done_d   = d_done_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (advance_s) begin
      if_done_d = 1'b0;
      d_done_d  = 1'b0;
    end else if (ack_s && granted_live_s) begin
      // An abandoned request completes on the bus but leaves no trace here
      if (grant_q == GNT_D) begin
        d_done_d = 1'b1;
        if (!mem_we_q) begin
          d_rdata_d = mem_rdata;
        end else begin
          d_rdata_d = d_rdata_q;
        end
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = mem_rdata;
      end
    end else begin
      if_done_d  = if_done_q;
      d_done_d   = d_done_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= GNT_I;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      grant_q     <= grant_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Output mapping
  always_comb begin
    if_stall  = i_pend_s;
    d_stall   = d_pend_s;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 2 time units after
// each rising edge; outputs are checked 1 time unit later.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_read_en;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_read_en;
  logic        d_write_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks;
  int failures;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_read_en(if_read_en),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .d_read_en (d_read_en),
    .d_write_en(d_write_en),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] fa;
    logic [31:0] prev_if;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    if_read_en = 1'b0;
    if_addr    = 32'h0;
    d_read_en  = 1'b0;
    d_write_en = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;

    // ---- reset values ----
    next_cyc;
    next_cyc;
    reset = 1'b0;
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_stalls", {30'h0, if_stall, d_stall}, 32'h0);

    // ---- D read, ack two cycles after mem_req rises ----
    next_cyc; // cycle 0
    d_read_en = 1'b1; d_addr = 32'h100;
    #1;
    check("dr_c0_stall", {31'h0, d_stall}, 32'h1);
    check("dr_c0_req", {31'h0, mem_req}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      next_cyc;
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      #1;
      check("dr_req", {31'h0, mem_req}, 32'h1);
      check("dr_addr", mem_addr, 32'h100);
      check("dr_we", {31'h0, mem_we}, 32'h0);
      check("dr_stall", {31'h0, d_stall}, 32'h1);
    end
    next_cyc; // cycle 4
    mem_ack = 1'b0;
    #1;
    check("dr_c4_req", {31'h0, mem_req}, 32'h0);
    check("dr_c4_stall", {31'h0, d_stall}, 32'h0);
    check("dr_c4_rdata", d_rdata, 32'hDEADBEEF);
    next_cyc;
    d_read_en = 1'b0;
    #1;
    check("dr_idle_stall", {30'h0, if_stall, d_stall}, 32'h0);

    // ---- simultaneous D read 0x200 and I read 0x40 ----
    next_cyc; // cycle 0
    d_read_en = 1'b1; d_addr = 32'h200;
    if_read_en = 1'b1; if_addr = 32'h40;
    #1;
    check("sim_c0_stalls", {30'h0, if_stall, d_stall}, 32'h3);
    next_cyc; // cycle 1
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    #1;
    check("sim_c1_req", {31'h0, mem_req}, 32'h1);
    check("sim_c1_addr", mem_addr, 32'h200);
    next_cyc; // cycle 2
    mem_ack = 1'b0;
    #1;
    check("sim_c2_req", {31'h0, mem_req}, 32'h0);
    check("sim_c2_stalls", {30'h0, if_stall, d_stall}, 32'h2);
    check("sim_c2_drdata", d_rdata, 32'h11111111);
    next_cyc; // cycle 3
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    #1;
    check("sim_c3_req", {31'h0, mem_req}, 32'h1);
    check("sim_c3_addr", mem_addr, 32'h40);
    check("sim_c3_we", {31'h0, mem_we}, 32'h0);
    check("sim_c3_dstall", {31'h0, d_stall}, 32'h0);
    next_cyc; // cycle 4: both complete, advance
    mem_ack = 1'b0;
    #1;
    check("sim_c4_stalls", {30'h0, if_stall, d_stall}, 32'h0);
    check("sim_c4_req", {31'h0, mem_req}, 32'h0);
    check("sim_c4_ifrdata", if_rdata, 32'h22222222);
    next_cyc; // cycle 5: next instruction still requesting, flags were cleared
    #1;
    check("sim_c5_stalls", {30'h0, if_stall, d_stall}, 32'h3);

    // ---- requests dropped while BUSY: data discarded ----
    next_cyc; // D granted again (0x200), requesters withdraw
    d_read_en = 1'b0; if_read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h33333333;
    #1;
    check("drop_req", {31'h0, mem_req}, 32'h1);
    next_cyc;
    mem_ack = 1'b0;
    #1;
    check("drop_req_fall", {31'h0, mem_req}, 32'h0);
    check("drop_drdata", d_rdata, 32'h11111111);
    check("drop_ifrdata", if_rdata, 32'h22222222);

    // ---- prime d_rdata with 0xA5A5A5A5 ----
    next_cyc;
    d_read_en = 1'b1; d_addr = 32'h280;
    next_cyc;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    next_cyc;
    mem_ack = 1'b0;
    #1;
    check("prime_rdata", d_rdata, 32'hA5A5A5A5);
    next_cyc;
    d_read_en = 1'b0;

    // ---- D write ----
    next_cyc; // cycle 0
    d_write_en = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678;
    #1;
    check("wr_c0_stall", {31'h0, d_stall}, 32'h1);
    for (int c = 1; c <= 2; c++) begin
      next_cyc;
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 32'hFFFF0000; end
      #1;
      check("wr_req", {31'h0, mem_req}, 32'h1);
      check("wr_we", {31'h0, mem_we}, 32'h1);
      check("wr_addr", mem_addr, 32'h300);
      check("wr_wdata", mem_wdata, 32'h12345678);
    end
    next_cyc;
    mem_ack = 1'b0;
    #1;
    check("wr_stall_low", {31'h0, d_stall}, 32'h0);
    check("wr_rdata_hold", d_rdata, 32'hA5A5A5A5);
    next_cyc;
    d_write_en = 1'b0;

    // ---- read and write both high: treated as a write ----
    next_cyc;
    d_read_en = 1'b1; d_write_en = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D;
    next_cyc;
    mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
    #1;
    check("rw_we", {31'h0, mem_we}, 32'h1);
    check("rw_wdata", mem_wdata, 32'hCAFEF00D);
    next_cyc;
    mem_ack = 1'b0;
    #1;
    check("rw_stall", {31'h0, d_stall}, 32'h0);
    check("rw_rdata_hold", d_rdata, 32'hA5A5A5A5);
    next_cyc;
    d_read_en = 1'b0; d_write_en = 1'b0;

    // ---- back-to-back fetches, immediate ack ----
    prev_if = 32'h22222222;
    for (int k = 0; k < 3; k++) begin
      fa = 32'h4 * k;
      next_cyc;
      if_read_en = 1'b1; if_addr = fa;
      #1;
      check("bf_stall_a", {31'h0, if_stall}, 32'h1);
      next_cyc;
      mem_ack = 1'b1; mem_rdata = 32'h1000 + fa;
      #1;
      check("bf_stall_b", {31'h0, if_stall}, 32'h1);
      check("bf_addr", mem_addr, fa);
      check("bf_rdata_old", if_rdata, prev_if);
      next_cyc;
      mem_ack = 1'b0;
      #1;
      check("bf_stall_c", {31'h0, if_stall}, 32'h0);
      check("bf_rdata_new", if_rdata, 32'h1000 + fa);
      prev_if = 32'h1000 + fa;
    end
    next_cyc;
    if_read_en = 1'b0;

    // ---- reset while BUSY, late ack ignored ----
    next_cyc;
    d_read_en = 1'b1; d_addr = 32'h600;
    next_cyc;
    #1;
    check("rb_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b1; d_read_en = 1'b0;
    next_cyc;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    check("rb_req_low", {31'h0, mem_req}, 32'h0);
    check("rb_addr", mem_addr, 32'h0);
    check("rb_drdata", d_rdata, 32'h0);
    check("rb_ifrdata", if_rdata, 32'h0);
    next_cyc;
    mem_ack = 1'b0;
    #1;
    check("rb_ack_ign_req", {31'h0, mem_req}, 32'h0);
    check("rb_ack_ign_d", d_rdata, 32'h0);
    check("rb_ack_ign_if", if_rdata, 32'h0);
    check("rb_stalls", {30'h0, if_stall, d_stall}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
